// File: rtl/input_conditioner_pkg.sv
// Shared constants and helpers for the input conditioner.
package input_conditioner_pkg;

  localparam int STAGES_DEF     = 3;
  localparam int FILTER_LEN_DEF = 4;
  localparam int STAGES_MIN     = 2;

  // Width of a counter that must hold values 0..filter_len without wrapping
  function automatic int cnt_width(input int filter_len);
    return $clog2(filter_len + 1);
  endfunction

endpackage

// File: rtl/input_conditioner_chan.sv
// One input channel: synchronizer chain, optional glitch filter, edge pulses.
// The glitch filter is built only when INPUT_CONDITIONER_FILTER_EN is defined;
// otherwise the output follows the synchronizer one cycle later.
module input_conditioner_chan
  import input_conditioner_pkg::*;
#(
  parameter int STAGES     = STAGES_DEF,
  parameter int FILTER_LEN = FILTER_LEN_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall
);

  if (STAGES < STAGES_MIN || FILTER_LEN < 1) begin : g_bad_params
    $error("input_conditioner_chan: STAGES must be >= 2 and FILTER_LEN >= 1");
  end

  logic [STAGES-1:0] sync_p0;
  logic              sync;
  logic              accept;

  assign sync = sync_p0[STAGES-1];

  // Synchronizer chain; bit 0 is the metastability-exposed flop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_p0 <= '0;
    else     sync_p0 <= {sync_p0[STAGES-2:0], din};
  end

`ifdef INPUT_CONDITIONER_FILTER_EN
  localparam int               CNT_W    = cnt_width(FILTER_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

  logic [CNT_W-1:0] cnt_p1;

  // A change is accepted on the FILTER_LEN-th consecutive disagreeing sample
  assign accept = (sync != dout) && (cnt_p1 == CNT_LAST);

  // Run length of disagreeing samples; restarts on agreement or acceptance
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          cnt_p1 <= '0;
    else if ((sync != dout) && !accept) cnt_p1 <= cnt_p1 + 1'b1;
    else                              cnt_p1 <= '0;
  end
`else
  assign accept = (sync != dout);
`endif

  // Filtered level plus one-cycle pulses aligned with the new level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      if (accept) dout <= sync;
      rise <= accept & sync;
      fall <= accept & ~sync;
    end
  end

endmodule

// File: rtl/input_conditioner.sv
// Input conditioner: WIDTH synchronized, filtered channels plus a one-deep
// event snapshot register with sticky overflow.
// Define INPUT_CONDITIONER_FILTER_EN to build the per-channel glitch filter.
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int STAGES     = STAGES_DEF,
  parameter int FILTER_LEN = FILTER_LEN_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] dat_in,
  output logic [WIDTH-1:0] dat_out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [WIDTH-1:0] evt_data,
  output logic             evt_ovf,
  input  logic             ovf_clr
);

  logic evt;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    input_conditioner_chan #(
      .STAGES     (STAGES),
      .FILTER_LEN (FILTER_LEN)
    ) u_chan (
      .clk  (clk),
      .rst  (rst),
      .din  (dat_in[i]),
      .dout (dat_out[i]),
      .rise (rise[i]),
      .fall (fall[i])
    );
  end

  assign evt = |(rise | fall);

  // Snapshot register: load when empty or being popped, flag loss otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      evt_valid <= 1'b0;
      evt_data  <= '0;
      evt_ovf   <= 1'b0;
    end else begin
      if (evt) begin
        if (!evt_valid || evt_ready) begin
          evt_valid <= 1'b1;
          evt_data  <= dat_out;
        end
      end else if (evt_ready) begin
        evt_valid <= 1'b0;
      end
      if (evt && evt_valid && !evt_ready) evt_ovf <= 1'b1;
      else if (ovf_clr)                   evt_ovf <= 1'b0;
    end
  end

endmodule
